dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters.
- Port A is the CPU memory stage (load/store); port B is the UART/debug loader.
- Fixed priority to A, with a starvation guard that forces one grant to B after a bounded wait.
- Tags each accepted access and routes its response back to the originator one cycle later.

Parameters:
- ADDR_WIDTH, 14, word-address width (matches dmem depth).
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive cycles B may wait before its grant is forced; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  CPU request.
- a_ready  out  1  CPU request accepted this cycle.
- a_addr  in  ADDR_WIDTH  CPU word address.
- a_wdata  in  DATA_WIDTH  CPU store data, pre-shifted to byte lanes.
- a_wstrb  in  4  CPU byte write enables; 0000 means read.
- a_rvalid  out  1  CPU response pulse.
- a_rdata  out  DATA_WIDTH  CPU read data.
- b_valid, b_ready, b_addr, b_wdata, b_wstrb, b_rvalid, b_rdata: same as the A-port signals, for the loader.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_din  out  DATA_WIDTH  RAM write data.
- mem_dout  in  DATA_WIDTH  RAM read data; valid one cycle after mem_en.

Behaviour:
- Reset values (rst held at a clk edge):
  - a_rvalid = b_rvalid = 0.
  - Starvation counter = 0; state = PRIO_A; response tag cleared.
  - Combinational outputs follow the rules below with the counter at 0.
- Grant logic is combinational from valid inputs and state; at most one grant per cycle.
- State PRIO_A:
  - a_valid=1 → grant A (a_ready=1).
  - else b_valid=1 → grant B.
  - else no grant, mem_en=0.
- State FORCE_B:
  - b_valid=1 → grant B even if a_valid=1; a_ready=0.
  - b_valid=0 → behave as PRIO_A.
  - Returns to PRIO_A on the next edge in either case.
- Starvation counter (4 bit):
  - Increments on each edge where b_valid=1 and B is not granted.
  - Clears on any edge where B is granted or b_valid=0.
  - When the counter reaches STARVE_LIMIT on an edge, the next state is FORCE_B and the counter clears.
- Memory drive on a grant:
  - mem_en=1; mem_addr, mem_din and mem_we come from the granted port, in the same cycle.
  - Non-granted requests leave the RAM untouched.
- Ready is combinational from valid. A requester must hold addr/wdata/wstrb stable while valid=1 and ready=0. Dropping valid before acceptance is allowed (request abandoned).
- Response:
  - On a grant, register tag {pending=1, port, is_read = (wstrb==0)}.
  - Next cycle the tagged port's rvalid=1 for exactly one cycle, for both reads and writes (writes are acknowledged).
  - rdata = mem_dout for reads, 0 for writes.
  - The non-tagged port's rvalid=0 and rdata=0.
- Back-to-back: a new grant may issue in the same cycle a previous response is delivered. Throughput is one access per cycle.
- Simultaneous write and read to the same address in consecutive cycles: the read returns the newly written data (RAM is write-first; the arbiter adds no bypass).
- Reset mid-operation: a pending tag is dropped and no rvalid is issued after rst. Any write on the rst cycle edge is suppressed (mem_en forced 0 while rst=1).
- No address decoding, alignment or sign extension; those stay in the CPU load/store unit.

Decomposition:
- Shared package holds:
  - PORT_A = 1'b0, PORT_B = 1'b1.
  - State encodings PRIO_A / FORCE_B.
  - WSTRB_READ = 4'b0000.
- One sub-module, arb_starve_ctr: the counter plus FORCE_B flag. Inputs: b_valid, b_granted. Output: force_b.
- Response tag register and muxes stay in the top.

Test Plan:
- Sole A read: preload word 5 = 32'hDEADBEEF; a_valid=1, a_addr=5, a_wstrb=0 → a_ready=1 same cycle; a_rvalid=1, a_rdata=32'hDEADBEEF next cycle; b_rvalid=0.
- B byte store: b_addr=7, b_wdata=32'hAABBCCDD, b_wstrb=4'b0010 over existing 32'h11223344 → mem_we=0010; b_rvalid pulse next cycle; readback = 32'h1122CC44.
- Contention with starvation: a_valid and b_valid held high continuously, STARVE_LIMIT=4 → grants A,A,A,A,B,A,A,A,A,B…; B is never delayed more than 4 cycles.
- Back-to-back ping-pong: A write addr 3 = 32'h12345678, then B read addr 3 next cycle → b_rdata=32'h12345678 two cycles after the A grant; each rvalid is exactly one cycle on the correct port.
- B abandons: b_valid high for 2 denied cycles, then low for 1, then high → counter restarts; the forced grant occurs after 4 more denied cycles, not 2.
- Reset mid-flight: A read granted, rst=1 on the next edge → no a_rvalid afterwards; mem_en=0 while rst; the first grant after rst is released behaves normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port identifiers, arbiter
// state encodings, the response tag layout and a read-detect helper.
package dmem_arbiter_pkg;

   // Port identifiers carried in the response tag.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Arbiter state encodings.
   localparam logic [0:0] PRIO_A  = 1'b0;
   localparam logic [0:0] FORCE_B = 1'b1;

   // A request with no byte enables set is a read.
   localparam logic [3:0] WSTRB_READ = 4'b0000;

   // Response tag registered on every grant and consumed one cycle later.
   typedef struct packed {
      logic pending;
      logic port;
      logic is_read;
   } resp_tag_t;

   function automatic logic wstrb_is_read(input logic [3:0] wstrb);
      return (wstrb == WSTRB_READ);
   endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Starvation guard for the loader port: counts consecutive cycles in which
// B is requesting but losing to A, and raises force_b for one cycle once the
// count reaches STARVE_LIMIT.
module arb_starve_ctr
   import dmem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic b_valid,
   input  logic b_granted,
   output logic force_b
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] cnt_p0;
   logic [0:0] state_p0;
   logic [3:0] cnt_inc;
   logic       b_denied;
   logic       limit_hit;

   assign cnt_inc   = cnt_p0 + 4'd1;
   assign b_denied  = b_valid && !b_granted;
   assign limit_hit = b_denied && (cnt_inc == LIMIT);

   // Count denied B cycles; reaching the limit arms FORCE_B for the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0   <= 4'd0;
         state_p0 <= PRIO_A;
      end else begin
         if (!b_denied || limit_hit) begin
            cnt_p0 <= 4'd0;
         end else begin
            cnt_p0 <= cnt_inc;
         end
         state_p0 <= limit_hit ? FORCE_B : PRIO_A;
      end
   end

   assign force_b = (state_p0 == FORCE_B);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU memory stage
// (port A, priority) and the UART/debug loader (port B). A starvation guard
// forces a B grant after a bounded wait. Each accepted access is tagged and
// its response is routed back to the originating port one cycle later.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 14,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic [3:0]            a_wstrb,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,

   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic [3:0]            b_wstrb,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,

   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   logic      force_b;
   logic      grant_a;
   logic      grant_b;
   logic      grant_any;
   resp_tag_t tag_p1;

   // Grants: A wins unless the guard is forcing B and B is asking; nothing
   // is granted while rst is high so no access can slip through reset.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         grant_b = b_valid && (force_b || !a_valid);
         grant_a = a_valid && !grant_b;
      end
   end

   assign grant_any = grant_a || grant_b;
   assign a_ready   = grant_a;
   assign b_ready   = grant_b;

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .rst       (rst),
      .b_valid   (b_valid),
      .b_granted (grant_b),
      .force_b   (force_b)
   );

   // RAM drive: the granted port owns every RAM input for this cycle.
   always_comb begin
      mem_en   = grant_any;
      mem_we   = 4'b0000;
      mem_addr = '0;
      mem_din  = '0;
      if (grant_b) begin
         mem_we   = b_wstrb;
         mem_addr = b_addr;
         mem_din  = b_wdata;
      end else if (grant_a) begin
         mem_we   = a_wstrb;
         mem_addr = a_addr;
         mem_din  = a_wdata;
      end
   end

   // ---- stage p0 -> p1: tag the accepted access for the response cycle ----
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_p1 <= '0;
      end else begin
         tag_p1.pending <= grant_any;
         tag_p1.port    <= grant_b ? PORT_B : PORT_A;
         tag_p1.is_read <= grant_b ? wstrb_is_read(b_wstrb) : wstrb_is_read(a_wstrb);
      end
   end

   // Response routing: RAM read data lands this cycle; writes return zero.
   always_comb begin
      a_rvalid = tag_p1.pending && (tag_p1.port == PORT_A);
      b_rvalid = tag_p1.pending && (tag_p1.port == PORT_B);
      a_rdata  = '0;
      b_rdata  = '0;
      if (a_rvalid && tag_p1.is_read) begin
         a_rdata = mem_dout;
      end
      if (b_rvalid && tag_p1.is_read) begin
         b_rdata = mem_dout;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small write-first RAM model.
module tb_dmem_arbiter;

   localparam int AW = 14;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_valid = 1'b0;
   logic          a_ready;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic [3:0]    a_wstrb = 4'b0000;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic [3:0]    b_wstrb = 4'b0000;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int total = 0;
   int bad   = 0;

   dmem_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_wstrb  (a_wstrb),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_wstrb  (b_wstrb),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // Write-first single-port RAM model (16 words are enough for the bench).
   logic [DW-1:0] ram [0:15];
   logic [DW-1:0] ram_merged;
   logic [3:0]    ram_idx;

   assign ram_idx = mem_addr[3:0];

   always_comb begin
      ram_merged = ram[ram_idx];
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) ram_merged[8*i +: 8] = mem_din[8*i +: 8];
      end
   end

   always @(posedge clk) begin
      if (mem_en) begin
         ram[ram_idx] <= ram_merged;
         mem_dout     <= ram_merged;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = 4'b0000;
      b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = 4'b0000;
   endtask

   // Full-word A store used to preload RAM contents through the DUT.
   task automatic preload_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      a_valid = 1'b1; a_addr = addr; a_wdata = data; a_wstrb = 4'b1111;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b1; a_addr = 14'd1; a_wdata = 32'hFFFF_FFFF; a_wstrb = 4'b1111;
      step();
      step();
      @(negedge clk);
      total++;
      if (a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_a_rvalid got=%b exp=0", a_rvalid); end
      total++;
      if (b_rvalid !== 1'b0) begin bad++; $display("FAIL reset_b_rvalid got=%b exp=0", b_rvalid); end
      total++;
      if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
      total++;
      if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
      step();
      clear_inputs();
      rst = 1'b0;
      step();
   endtask

   task automatic test_a_read();
      preload_a(14'd5, 32'hDEADBEEF);
      a_valid = 1'b1; a_addr = 14'd5; a_wstrb = 4'b0000;
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL aread_ready got=%b exp=1", a_ready); end
      total++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 14'd5})
         begin bad++; $display("FAIL aread_memdrive got=%b/%b/%0d exp=1/0000/5", mem_en, mem_we, mem_addr); end
      step();
      clear_inputs();
      @(negedge clk);
      total++;
      if (a_rvalid !== 1'b1) begin bad++; $display("FAIL aread_rvalid got=%b exp=1", a_rvalid); end
      total++;
      if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL aread_rdata got=%h exp=deadbeef", a_rdata); end
      total++;
      if (b_rvalid !== 1'b0) begin bad++; $display("FAIL aread_b_rvalid got=%b exp=0", b_rvalid); end
      step();
      @(negedge clk);
      total++;
      if (a_rvalid !== 1'b0) begin bad++; $display("FAIL aread_pulse_width got=%b exp=0", a_rvalid); end
      step();
   endtask

   task automatic test_b_byte_store();
      preload_a(14'd7, 32'h11223344);
      b_valid = 1'b1; b_addr = 14'd7; b_wdata = 32'hAABBCCDD; b_wstrb = 4'b0010;
      @(negedge clk);
      total++;
      if (b_ready !== 1'b1) begin bad++; $display("FAIL bstore_ready got=%b exp=1", b_ready); end
      total++;
      if (mem_we !== 4'b0010) begin bad++; $display("FAIL bstore_mem_we got=%b exp=0010", mem_we); end
      total++;
      if (mem_din !== 32'hAABBCCDD) begin bad++; $display("FAIL bstore_mem_din got=%h exp=aabbccdd", mem_din); end
      step();
      b_wstrb = 4'b0000;
      @(negedge clk);
      total++;
      if (b_rvalid !== 1'b1) begin bad++; $display("FAIL bstore_ack got=%b exp=1", b_rvalid); end
      total++;
      if (b_rdata !== 32'h0) begin bad++; $display("FAIL bstore_ack_data got=%h exp=0", b_rdata); end
      total++;
      if (a_rvalid !== 1'b0) begin bad++; $display("FAIL bstore_a_rvalid got=%b exp=0", a_rvalid); end
      step();
      clear_inputs();
      @(negedge clk);
      total++;
      if (b_rdata !== 32'h1122CC44) begin bad++; $display("FAIL bstore_readback got=%h exp=1122cc44", b_rdata); end
      step();
   endtask

   task automatic test_starvation();
      logic exp_b;
      a_valid = 1'b1; a_addr = 14'd0; a_wstrb = 4'b0000;
      b_valid = 1'b1; b_addr = 14'd1; b_wstrb = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         exp_b = (i == 4) || (i == 9);
         @(negedge clk);
         total++;
         if ({a_ready, b_ready} !== {!exp_b, exp_b})
            begin bad++; $display("FAIL starve_cycle%0d got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, !exp_b, exp_b); end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      a_valid = 1'b1; a_addr = 14'd3; a_wdata = 32'h12345678; a_wstrb = 4'b1111;
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_a_ready got=%b exp=1", a_ready); end
      step();
      clear_inputs();
      b_valid = 1'b1; b_addr = 14'd3; b_wstrb = 4'b0000;
      @(negedge clk);
      total++;
      if ({a_rvalid, b_rvalid, b_ready} !== 3'b101)
         begin bad++; $display("FAIL b2b_cycle1 got a_rv=%b b_rv=%b b_rdy=%b exp 1 0 1", a_rvalid, b_rvalid, b_ready); end
      total++;
      if (a_rdata !== 32'h0) begin bad++; $display("FAIL b2b_a_ack_data got=%h exp=0", a_rdata); end
      step();
      clear_inputs();
      @(negedge clk);
      total++;
      if ({a_rvalid, b_rvalid} !== 2'b01)
         begin bad++; $display("FAIL b2b_cycle2 got a_rv=%b b_rv=%b exp 0 1", a_rvalid, b_rvalid); end
      total++;
      if (b_rdata !== 32'h12345678) begin bad++; $display("FAIL b2b_b_rdata got=%h exp=12345678", b_rdata); end
      step();
      @(negedge clk);
      total++;
      if ({a_rvalid, b_rvalid} !== 2'b00)
         begin bad++; $display("FAIL b2b_cycle3 got a_rv=%b b_rv=%b exp 0 0", a_rvalid, b_rvalid); end
      step();
   endtask

   task automatic test_b_abandon();
      logic exp_b;
      a_valid = 1'b1; a_addr = 14'd0; a_wstrb = 4'b0000;
      b_valid = 1'b1; b_addr = 14'd1; b_wstrb = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (b_ready !== 1'b0) begin bad++; $display("FAIL abandon_pre%0d got=%b exp=0", i, b_ready); end
         step();
      end
      b_valid = 1'b0;
      step();
      b_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_b = (i == 4);
         @(negedge clk);
         total++;
         if ({a_ready, b_ready} !== {!exp_b, exp_b})
            begin bad++; $display("FAIL abandon_post%0d got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, !exp_b, exp_b); end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_reset_midflight();
      preload_a(14'd9, 32'hCAFEF00D);
      a_valid = 1'b1; a_addr = 14'd9; a_wstrb = 4'b0000;
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL midrst_grant got=%b exp=1", a_ready); end
      step();
      rst = 1'b1;
      a_wdata = 32'h0; a_wstrb = 4'b1111;
      @(negedge clk);
      total++;
      if ({mem_en, a_ready} !== 2'b00)
         begin bad++; $display("FAIL midrst_mem_en got en=%b rdy=%b exp 0 0", mem_en, a_ready); end
      step();
      @(negedge clk);
      total++;
      if ({a_rvalid, b_rvalid, mem_en} !== 3'b000)
         begin bad++; $display("FAIL midrst_after got a_rv=%b b_rv=%b en=%b exp 0 0 0", a_rvalid, b_rvalid, mem_en); end
      step();
      rst = 1'b0;
      a_wstrb = 4'b0000;
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL midrst_regrant got=%b exp=1", a_ready); end
      step();
      clear_inputs();
      @(negedge clk);
      total++;
      if ({a_rvalid, a_rdata} !== {1'b1, 32'hCAFEF00D})
         begin bad++; $display("FAIL midrst_read got rv=%b data=%h exp 1 cafef00d", a_rvalid, a_rdata); end
      step();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_a_read();
      test_b_byte_store();
      test_starvation();
      test_back_to_back();
      test_b_abandon();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
